note_sequencer: RTL and testbench

//  Plays a programmable note sequence on the square-wave datapath.

---
 rtl/note_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_note_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
`timescale 1ns/1ps
// note_sequencer
//   Plays a programmable {half_period, duration} note table on the square-wave
//   generator. Durations and inter-note gaps are counted in DAC samples
//   (next_sample pulses). The table is writable only while IDLE.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   next_sample         1-cycle pulse, DAC consumed a sample
//   play_pulse          play / pause toggle
//   stop_pulse          stop and rewind to note 0
//   skip_pulse          jump to the next note (no gap)
//   loop_en             wrap to note 0 at end of sequence
//   cfg_we/addr/...     table write port
//   cfg_err             1-cycle pulse when a write is rejected (not IDLE)
//   tone_en             generator enable
//   tone_half_period    generator half period (held while tone_en=0)
//   note_idx            current table index
//   seq_done            1-cycle pulse at the end of a non-looping sequence
//   leds                {state[1:0], note_idx[1:0]}
module note_sequencer #(
  parameter int unsigned NUM_NOTES   = 8,
  parameter int unsigned PW          = 16,
  parameter int unsigned DW          = 16,
  parameter int unsigned GAP_SAMPLES = 64,
  localparam int unsigned AW = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          next_sample,
  input  logic          play_pulse,
  input  logic          stop_pulse,
  input  logic          skip_pulse,
  input  logic          loop_en,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [PW-1:0] cfg_half_period,
  input  logic [DW-1:0] cfg_dur,
  output logic          cfg_err,
  output logic          tone_en,
  output logic [PW-1:0] tone_half_period,
  output logic [AW-1:0] note_idx,
  output logic          seq_done,
  output logic [3:0]    leds
);

  localparam int unsigned GW = (GAP_SAMPLES > 0) ? $clog2(GAP_SAMPLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_GAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t        state_q, state_d, ret_q, ret_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] dur_cnt_q, dur_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          tone_en_q, tone_en_d;
  logic [PW-1:0] tone_hp_q, tone_hp_d;
  logic          seq_done_q, seq_done_d;
  logic          cfg_err_q, cfg_err_d;
  logic [3:0]    leds_q, leds_d;
  logic [PW-1:0] hp_q  [NUM_NOTES];
  logic [PW-1:0] hp_d  [NUM_NOTES];
  logic [DW-1:0] dur_q [NUM_NOTES];
  logic [DW-1:0] dur_d [NUM_NOTES];

  logic          last;
  logic [AW-1:0] nidx;
  logic          at_end;
  logic          do_adv;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    idx_d      = idx_q;
    dur_cnt_d  = dur_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tone_en_d  = tone_en_q;
    tone_hp_d  = tone_hp_q;
    seq_done_d = 1'b0;
    cfg_err_d  = 1'b0;
    hp_d       = hp_q;
    dur_d      = dur_q;
    do_adv     = 1'b0;

    // nidx is only dereferenced when idx is not the last slot
    last   = (idx_q == AW'(NUM_NOTES - 1));
    nidx   = last ? '0 : idx_q + 1'b1;
    at_end = last || (dur_q[nidx] == '0);

    if (cfg_we) begin
      if (state_q == S_IDLE) begin
        hp_d[cfg_addr]  = cfg_half_period;
        dur_d[cfg_addr] = cfg_dur;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (play_pulse) begin
          if (dur_q[0] != '0) begin
            state_d   = S_PLAY;
            idx_d     = '0;
            dur_cnt_d = dur_q[0];
            tone_en_d = 1'b1;
            tone_hp_d = hp_q[0];
          end else begin
            seq_done_d = 1'b1;
          end
        end
      end
      S_PLAY, S_GAP: begin
        if (stop_pulse) begin
          state_d   = S_IDLE;
          idx_d     = '0;
          tone_en_d = 1'b0;
        end else if (play_pulse) begin
          state_d   = S_PAUSE;
          ret_d     = state_q;
          tone_en_d = 1'b0;
        end else if (skip_pulse) begin
          // also absorbs a coincident terminal next_sample: one advance only
          do_adv = 1'b1;
        end else if (next_sample) begin
          if (state_q == S_PLAY) begin
            if (dur_cnt_q == DW'(1)) begin
              if (GAP_SAMPLES != 0) begin
                state_d   = S_GAP;
                tone_en_d = 1'b0;
                gap_cnt_d = GW'(GAP_SAMPLES);
              end else begin
                do_adv = 1'b1;
              end
            end else begin
              dur_cnt_d = dur_cnt_q - 1'b1;
            end
          end else begin
            if (gap_cnt_q == GW'(1)) do_adv = 1'b1;
            else                     gap_cnt_d = gap_cnt_q - 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (stop_pulse) begin
          state_d   = S_IDLE;
          idx_d     = '0;
          tone_en_d = 1'b0;
        end else if (play_pulse) begin
          state_d   = ret_q;
          tone_en_d = (ret_q == S_PLAY);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_adv) begin
      if (at_end && !(loop_en && dur_q[0] != '0)) begin
        state_d    = S_IDLE;
        idx_d      = '0;
        tone_en_d  = 1'b0;
        seq_done_d = !loop_en;
      end else begin
        state_d   = S_PLAY;
        idx_d     = at_end ? '0 : nidx;
        dur_cnt_d = dur_q[idx_d];
        tone_en_d = 1'b1;
        tone_hp_d = hp_q[idx_d];
      end
    end

    leds_d = {state_d, 2'(idx_d)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      idx_q      <= '0;
      dur_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tone_en_q  <= 1'b0;
      tone_hp_q  <= '0;
      seq_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      leds_q     <= '0;
      for (int unsigned i = 0; i < NUM_NOTES; i++) begin
        hp_q[i]  <= '0;
        dur_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      idx_q      <= idx_d;
      dur_cnt_q  <= dur_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tone_en_q  <= tone_en_d;
      tone_hp_q  <= tone_hp_d;
      seq_done_q <= seq_done_d;
      cfg_err_q  <= cfg_err_d;
      leds_q     <= leds_d;
      hp_q       <= hp_d;
      dur_q      <= dur_d;
    end
  end

  assign cfg_err          = cfg_err_q;
  assign tone_en          = tone_en_q;
  assign tone_half_period = tone_hp_q;
  assign note_idx         = idx_q;
  assign seq_done         = seq_done_q;
  assign leds             = leds_q;

endmodule

// File: tb/tb_note_sequencer.sv
`timescale 1ns/1ps
module tb_note_sequencer;

  localparam logic [4:0] E_NONE = 5'd0;
  localparam logic [4:0] E_NEXT = 5'd1;
  localparam logic [4:0] E_PLAY = 5'd2;
  localparam logic [4:0] E_STOP = 5'd4;
  localparam logic [4:0] E_SKIP = 5'd8;
  localparam logic [4:0] E_WE   = 5'd16;
  localparam logic [1:0] I = 2'd0, P = 2'd1, G = 2'd2, Z = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        next_sample = 1'b0, play_pulse = 1'b0, stop_pulse = 1'b0, skip_pulse = 1'b0;
  logic        loop_en = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_half_period = '0;
  logic [15:0] cfg_dur = '0;
  logic        cfg_err, tone_en, seq_done;
  logic [15:0] tone_half_period;
  logic [2:0]  note_idx;
  logic [3:0]  leds;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        te;
    logic [15:0] hp;
    logic [2:0]  idx;
    logic [1:0]  st;
    logic        sd;
    logic        err;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] ev_q[$];

  note_sequencer #(.NUM_NOTES(8), .PW(16), .DW(16), .GAP_SAMPLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .next_sample(next_sample), .play_pulse(play_pulse),
    .stop_pulse(stop_pulse), .skip_pulse(skip_pulse), .loop_en(loop_en),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_half_period(cfg_half_period),
    .cfg_dur(cfg_dur), .cfg_err(cfg_err), .tone_en(tone_en),
    .tone_half_period(tone_half_period), .note_idx(note_idx), .seq_done(seq_done),
    .leds(leds)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [25:0] dut_vec();
    return {tone_en, tone_half_period, note_idx, seq_done, cfg_err, leds};
  endfunction

  function automatic logic [25:0] exp_vec(input exp_t e);
    return {e.te, e.hp, e.idx, e.sd, e.err, e.st, e.idx[1:0]};
  endfunction

  // queue one stimulus event together with the outputs it must produce
  task automatic plan(input logic [4:0] ev, input logic te, input logic [15:0] hp,
                      input logic [2:0] idx, input logic [1:0] st,
                      input logic sd, input logic err);
    exp_t e;
    e.te = te; e.hp = hp; e.idx = idx; e.st = st; e.sd = sd; e.err = err;
    ev_q.push_back(ev);
    sb.push_back(e);
  endtask

  // called at posedge+1; applies inputs for one cycle, returns at next posedge+1
  task automatic step(input logic [4:0] ev);
    {cfg_we, skip_pulse, stop_pulse, play_pulse, next_sample} = ev;
    @(posedge clk); #1;
    {cfg_we, skip_pulse, stop_pulse, play_pulse, next_sample} = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] hp, input logic [15:0] d);
    cfg_addr = a; cfg_half_period = hp; cfg_dur = d;
    step(E_WE);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (dut_vec() !== 26'd0) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", dut_vec(), 26'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sequence();
    exp_t e; int n = 0;
    wr(0, 100, 5); wr(1, 200, 3); wr(2, 50, 0);
    plan(E_PLAY, 1, 100, 0, P, 0, 0);
    repeat (4) plan(E_NEXT, 1, 100, 0, P, 0, 0);
    repeat (2) plan(E_NEXT, 0, 100, 0, G, 0, 0);
    plan(E_NEXT, 1, 200, 1, P, 0, 0);
    repeat (2) plan(E_NEXT, 1, 200, 1, P, 0, 0);
    repeat (2) plan(E_NEXT, 0, 200, 1, G, 0, 0);
    plan(E_NEXT, 0, 200, 0, I, 1, 0);
    plan(E_NONE, 0, 200, 0, I, 0, 0);
    while (ev_q.size() > 0) begin
      step(ev_q.pop_front()); e = sb.pop_front(); checks++; n++;
      if (dut_vec() !== exp_vec(e)) begin
        failures++;
        $display("FAIL sequence step %0d got=%h exp=%h", n, dut_vec(), exp_vec(e));
      end
    end
  endtask

  task automatic test_loop();
    exp_t e; int n = 0;
    loop_en = 1'b1;
    plan(E_PLAY, 1, 100, 0, P, 0, 0);
    repeat (4) plan(E_NEXT, 1, 100, 0, P, 0, 0);
    repeat (2) plan(E_NEXT, 0, 100, 0, G, 0, 0);
    repeat (3) plan(E_NEXT, 1, 200, 1, P, 0, 0);
    repeat (2) plan(E_NEXT, 0, 200, 1, G, 0, 0);
    plan(E_NEXT, 1, 100, 0, P, 0, 0);
    plan(E_STOP, 0, 100, 0, I, 0, 0);
    while (ev_q.size() > 0) begin
      step(ev_q.pop_front()); e = sb.pop_front(); checks++; n++;
      if (dut_vec() !== exp_vec(e)) begin
        failures++;
        $display("FAIL loop step %0d got=%h exp=%h", n, dut_vec(), exp_vec(e));
      end
    end
    loop_en = 1'b0;
  endtask

  task automatic test_pause();
    exp_t e; int n = 0;
    plan(E_PLAY, 1, 100, 0, P, 0, 0);
    repeat (2) plan(E_NEXT, 1, 100, 0, P, 0, 0);
    plan(E_PLAY, 0, 100, 0, Z, 0, 0);
    repeat (10) plan(E_NEXT, 0, 100, 0, Z, 0, 0);
    plan(E_PLAY, 1, 100, 0, P, 0, 0);
    repeat (2) plan(E_NEXT, 1, 100, 0, P, 0, 0);
    plan(E_NEXT, 0, 100, 0, G, 0, 0);
    plan(E_STOP, 0, 100, 0, I, 0, 0);
    while (ev_q.size() > 0) begin
      step(ev_q.pop_front()); e = sb.pop_front(); checks++; n++;
      if (dut_vec() !== exp_vec(e)) begin
        failures++;
        $display("FAIL pause step %0d got=%h exp=%h", n, dut_vec(), exp_vec(e));
      end
    end
  endtask

  task automatic test_stop_skip();
    exp_t e; int n = 0;
    plan(E_PLAY, 1, 100, 0, P, 0, 0);
    plan(E_SKIP, 1, 200, 1, P, 0, 0);
    plan(E_STOP | E_SKIP, 0, 200, 0, I, 0, 0);
    plan(E_NONE, 0, 200, 0, I, 0, 0);
    // skip colliding with the terminal sample of note 0
    plan(E_PLAY, 1, 100, 0, P, 0, 0);
    repeat (4) plan(E_NEXT, 1, 100, 0, P, 0, 0);
    plan(E_NEXT | E_SKIP, 1, 200, 1, P, 0, 0);
    plan(E_NEXT, 1, 200, 1, P, 0, 0);
    plan(E_STOP, 0, 200, 0, I, 0, 0);
    // skip ignored in PAUSE and IDLE
    plan(E_PLAY, 1, 100, 0, P, 0, 0);
    plan(E_PLAY, 0, 100, 0, Z, 0, 0);
    plan(E_SKIP, 0, 100, 0, Z, 0, 0);
    plan(E_PLAY, 1, 100, 0, P, 0, 0);
    plan(E_STOP, 0, 100, 0, I, 0, 0);
    plan(E_SKIP, 0, 100, 0, I, 0, 0);
    while (ev_q.size() > 0) begin
      step(ev_q.pop_front()); e = sb.pop_front(); checks++; n++;
      if (dut_vec() !== exp_vec(e)) begin
        failures++;
        $display("FAIL stop_skip step %0d got=%h exp=%h", n, dut_vec(), exp_vec(e));
      end
    end
  endtask

  task automatic test_cfg_err();
    exp_t e; int n = 0;
    step(E_PLAY);
    cfg_addr = 3'd0; cfg_half_period = 16'd999; cfg_dur = 16'd9;
    plan(E_WE, 1, 100, 0, P, 0, 1);
    plan(E_NONE, 1, 100, 0, P, 0, 0);
    plan(E_STOP, 0, 100, 0, I, 0, 0);
    while (ev_q.size() > 0) begin
      step(ev_q.pop_front()); e = sb.pop_front(); checks++; n++;
      if (dut_vec() !== exp_vec(e)) begin
        failures++;
        $display("FAIL cfg_err step %0d got=%h exp=%h", n, dut_vec(), exp_vec(e));
      end
    end
    // accepted IDLE write raises no error; old entry {100,5} still in place
    cfg_half_period = 16'd100; cfg_dur = 16'd5;
    plan(E_WE, 0, 100, 0, I, 0, 0);
    plan(E_PLAY, 1, 100, 0, P, 0, 0);
    repeat (4) plan(E_NEXT, 1, 100, 0, P, 0, 0);
    plan(E_NEXT, 0, 100, 0, G, 0, 0);
    plan(E_STOP, 0, 100, 0, I, 0, 0);
    while (ev_q.size() > 0) begin
      step(ev_q.pop_front()); e = sb.pop_front(); checks++; n++;
      if (dut_vec() !== exp_vec(e)) begin
        failures++;
        $display("FAIL cfg_readback step %0d got=%h exp=%h", n, dut_vec(), exp_vec(e));
      end
    end
  endtask

  task automatic test_last_entry();
    exp_t e; int n = 0;
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(10 + i), 16'd1);
    plan(E_PLAY, 1, 10, 0, P, 0, 0);
    for (int i = 1; i < 8; i++) plan(E_SKIP, 1, 16'(10 + i), 3'(i), P, 0, 0);
    plan(E_SKIP, 0, 17, 0, I, 1, 0);
    while (ev_q.size() > 0) begin
      step(ev_q.pop_front()); e = sb.pop_front(); checks++; n++;
      if (dut_vec() !== exp_vec(e)) begin
        failures++;
        $display("FAIL last_entry step %0d got=%h exp=%h", n, dut_vec(), exp_vec(e));
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; int n = 0;
    plan(E_PLAY, 1, 10, 0, P, 0, 0);
    plan(E_NEXT, 0, 10, 0, G, 0, 0);
    while (ev_q.size() > 0) begin
      step(ev_q.pop_front()); e = sb.pop_front(); checks++; n++;
      if (dut_vec() !== exp_vec(e)) begin
        failures++;
        $display("FAIL reset_mid step %0d got=%h exp=%h", n, dut_vec(), exp_vec(e));
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 26'd0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", dut_vec(), 26'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    plan(E_PLAY, 0, 0, 0, I, 1, 0);
    plan(E_NONE, 0, 0, 0, I, 0, 0);
    while (ev_q.size() > 0) begin
      step(ev_q.pop_front()); e = sb.pop_front(); checks++; n++;
      if (dut_vec() !== exp_vec(e)) begin
        failures++;
        $display("FAIL reset_empty step %0d got=%h exp=%h", n, dut_vec(), exp_vec(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_loop();
    test_pause();
    test_stop_skip();
    test_cfg_err();
    test_last_entry();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
